// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between MEM stage and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory target with fixed wait states and access checking
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            resetn,
    dmem_responder_if.slave bus
);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 0..15");
        end
        if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        req_ready_w;
    logic        accept;
    logic        enter_resp;
    logic        handshake;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        cur_write;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [1:0]  cur_lane;
    logic [AW-1:0] cur_idx;
    logic [3:0]  cur_be;
    logic [31:0] cur_wd;
    logic [31:0] rd_word;
    logic [31:0] load_data;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready_w = ready_q && (state == S_IDLE);
    assign accept      = bus.req_valid && req_ready_w;
    assign handshake   = resp_valid_q && bus.resp_ready;
    assign enter_resp  = (state != S_RESP) && (state_nxt == S_RESP);

    assign bus.req_ready  = req_ready_w;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // With LATENCY==0 the request enters RESP on its accept edge, so the live bus is used.
    assign cur_write = (state == S_IDLE) ? bus.req_write : lat_write;
    assign cur_size  = (state == S_IDLE) ? bus.req_size  : lat_size;
    assign cur_addr  = (state == S_IDLE) ? bus.req_addr  : lat_addr;
    assign cur_wdata = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
    assign cur_lane  = cur_addr[1:0];
    assign cur_idx   = cur_addr[AW+1:2];
    assign rd_word   = mem[cur_idx];

    always_comb begin
        cur_err   = 1'b0;
        cur_be    = 4'b0000;
        cur_wd    = cur_wdata;
        load_data = rd_word;
        case (cur_size)
            2'b00: begin
                cur_be    = 4'b0001 << cur_lane;
                cur_wd    = {4{cur_wdata[7:0]}};
                load_data = {24'h0, rd_word[8*cur_lane +: 8]};
            end
            2'b01: begin
                cur_err   = cur_addr[0];
                cur_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                cur_wd    = {2{cur_wdata[15:0]}};
                load_data = {16'h0, rd_word[16*cur_addr[1] +: 16]};
            end
            2'b10: begin
                cur_err = |cur_addr[1:0];
                cur_be  = 4'b1111;
            end
            default: cur_err = 1'b1;
        endcase
        if (cur_addr[31:2] >= 30'(DEPTH_WORDS)) begin
            cur_err = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP: if (handshake) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            if (accept) begin
                cnt       <= 4'(LAT_M1);
                lat_write <= bus.req_write;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Response payload is captured on RESP entry; valid follows one edge later.
            if (enter_resp) begin
                rdata_q <= (cur_write || cur_err) ? 32'h0 : load_data;
                err_q   <= cur_err;
            end else if (handshake) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if (handshake) begin
                resp_valid_q <= 1'b0;
            end else if (state == S_RESP) begin
                resp_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wd[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (LATENCY=2 and LATENCY=0 builds)
module tb_dmem_responder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        @(negedge clk);
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = a ^ 32'h4;
        bus.req_wdata = ~d;
        bus.req_size  = 2'b10;
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", bus.resp_rdata); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", bus.resp_err); end
        resetn = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b expected 0", bus.req_ready); end
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b expected 1", bus.req_ready); end
        total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL ready0_after_edge: got %b expected 1", bus0.req_ready); end
    endtask

    task automatic test_word_rw;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL store_latency: got %0d expected 3", lat); end
        total++; if ({er, rd} !== 33'h0) begin bad++; $display("FAIL store_resp: got err=%b rdata=%h expected 0/0", er, rd); end
        do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL load_latency: got %0d expected 3", lat); end
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL load_word: got %h err=%b expected deadbeef err=0", rd, er); end
    endtask

    task automatic test_lanes;
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_d [4] = '{32'h0, 32'hA5ADBEEF, 32'h000000A5, 32'h0000A5AD};
        logic [1:0]  szs   [4] = '{2'b00, 2'b10, 2'b00, 2'b01};
        logic [31:0] adrs  [4] = '{32'h13, 32'h10, 32'h13, 32'h12};
        for (int i = 0; i < 4; i++) begin
            do_req(i == 0, szs[i], adrs[i], 32'h000000A5, rd, er, lat);
            total++; if (rd !== exp_d[i] || er !== 1'b0) begin bad++; $display("FAIL lane_%0d: got %h err=%b expected %h err=0", i, rd, er, exp_d[i]); end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        logic        wrs  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  szs  [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] adrs [4] = '{32'h11, 32'h12, 32'h10, 32'h00001000};
        for (int i = 0; i < 4; i++) begin
            do_req(wrs[i], szs[i], adrs[i], 32'h11223344, rd, er, lat);
            total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_%0d: got err=%b rdata=%h expected 1/0", i, er, rd); end
        end
        do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hA5ADBEEF || er !== 1'b0) begin bad++; $display("FAIL err_unchanged: got %h err=%b expected a5adbeef", rd, er); end
        do_req(1'b1, 2'b10, 32'hFFC, 32'h0BADF00D, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL top_word_store: got err=%b expected 0", er); end
        do_req(1'b0, 2'b10, 32'hFFC, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin bad++; $display("FAIL top_word_load: got %h err=%b expected 0badf00d", rd, er); end
    endtask

    task automatic test_backpressure;
        int n;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_size = 2'b00; bus.req_addr = 32'h13;
        n = 0;
        while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL bp_latency: got %0d expected 3", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hA5ADBEEF || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h e=%b rdy=%b expected 1/a5adbeef/0/0", i,
                         bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            end
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got v=%b rdy=%b expected 0/1", bus.resp_valid, bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
        total++; if (bus.resp_rdata !== 32'h000000A5 || n !== 3) begin bad++; $display("FAIL bp_pending: got %h lat=%0d expected 000000a5 lat=3", bus.resp_rdata, n); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat; int n;
        do_req(1'b1, 2'b10, 32'h20, 32'hCAFEF00D, rd, er, lat);
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_reset: got v=%b rdy=%b expected 0/0", bus.resp_valid, bus.req_ready); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_req(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL mid_reset_mem: got %h err=%b expected cafef00d", rd, er); end
    endtask

    task automatic test_back_to_back;
        int acc [4];
        int n_acc = 0;
        int first_resp = -1;
        logic [31:0] rd0 = 32'hFFFFFFFF;
        @(negedge clk);
        bus0.req_write = 1'b1; bus0.req_size = 2'b10; bus0.req_addr = 32'h0;
        bus0.req_wdata = 32'h000055AA; bus0.req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus0.req_valid && bus0.req_ready && n_acc < 4) begin
                acc[n_acc] = cyc + 1;
                n_acc++;
            end
            if (bus0.resp_valid && first_resp < 0) begin
                first_resp = cyc;
                rd0 = bus0.resp_rdata;
            end
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;
        total++; if (n_acc < 2) begin bad++; $display("FAIL b2b_accepts: got %0d expected >=2", n_acc); end
        else begin
            total++; if (acc[1] - acc[0] !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d expected 3", acc[1] - acc[0]); end
            total++; if (first_resp - acc[0] !== 1) begin bad++; $display("FAIL lat0_resp: got %0d expected 1", first_resp - acc[0]); end
        end
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL lat0_store_rdata: got %h expected 0", rd0); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b00;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0; bus0.resp_ready = 1'b1;
        test_reset();
        test_word_rw();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
